// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_dbg_pkg
//  Description : Shared constants for the UART memory debug bridge: state
//                encoding, header bit positions, status bytes, response width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_dbg_pkg;

    localparam int unsigned C_RESP_W     = 42;
    localparam int unsigned C_RESP_BYTES = 6;
    localparam int unsigned C_STATE_W    = 3;

    localparam logic [C_STATE_W-1:0] C_ST_IDLE      = 3'd0;
    localparam logic [C_STATE_W-1:0] C_ST_RX_ADDR   = 3'd1;
    localparam logic [C_STATE_W-1:0] C_ST_RX_DATA   = 3'd2;
    localparam logic [C_STATE_W-1:0] C_ST_ISSUE     = 3'd3;
    localparam logic [C_STATE_W-1:0] C_ST_WAIT_RESP = 3'd4;
    localparam logic [C_STATE_W-1:0] C_ST_TX_RESP   = 3'd5;
    localparam logic [C_STATE_W-1:0] C_ST_TX_STAT   = 3'd6;
    localparam logic [C_STATE_W-1:0] C_ST_RX_CSUM   = 3'd7;

    localparam int unsigned C_HDR_RW_BIT    = 7;
    localparam int unsigned C_HDR_TYPE_BIT  = 6;
    localparam int unsigned C_HDR_ADDR8_BIT = 0;

    localparam logic [7:0] C_ACK_BYTE  = 8'hA5;
    localparam logic [7:0] C_ERR_BYTE  = 8'hEE;
    localparam logic [7:0] C_BUSY_BYTE = 8'hE1;

    function automatic logic [7:0] xor_bytes(input logic [8*C_RESP_BYTES-1:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < int'(C_RESP_BYTES); i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_resp_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_resp_serializer
//  Description : Parallel-loads up to MAX_BYTES bytes and shifts them out MSB
//                byte first under a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_serializer #(
    parameter int unsigned MAX_BYTES = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [8*MAX_BYTES-1:0] load_data,
    input  logic [2:0]             load_len,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   done
);

    logic [8*MAX_BYTES-1:0] r_shift;
    logic [2:0]             r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (load) begin
            r_shift <= load_data;
            r_count <= load_len;
        end else if (tx_valid && tx_ready) begin
            r_shift <= r_shift << 8;
            r_count <= r_count - 3'd1;
        end
    end

    assign tx_valid = (r_count != 3'd0);
    assign tx_byte  = r_shift[8*MAX_BYTES-1 -: 8];
    assign done     = tx_valid && tx_ready && (r_count == 3'd1);

endmodule
`default_nettype wire

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_bridge
//  Description : Host byte frames over UART -> one debug memory access per
//                frame; read response or status byte returned over TX.
//                Optional frame/response checksum: UART_MEM_BRIDGE_CSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_bridge
    import uart_dbg_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT   = 100000,
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter logic [7:0]  ACK_BYTE     = C_ACK_BYTE,
    parameter logic [7:0]  ERR_BYTE     = C_ERR_BYTE,
    parameter logic [7:0]  BUSY_BYTE    = C_BUSY_BYTE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                cpu_enable,
    output logic                write_mem_req,
    output logic                target_mem_type,
    output logic [8:0]          target_addr,
    output logic                rw_flag,
    output logic [31:0]         uart_rx_data,
    input  logic [C_RESP_W-1:0] mem_tx_data,
    input  logic                mem_tx_data_ready,
    output logic                busy
);

`ifdef UART_MEM_BRIDGE_CSUM_EN
    localparam int unsigned          C_TX_BYTES   = C_RESP_BYTES + 1;
    localparam logic [C_STATE_W-1:0] C_ST_PAYLOAD = C_ST_RX_CSUM;
`else
    localparam int unsigned          C_TX_BYTES   = C_RESP_BYTES;
    localparam logic [C_STATE_W-1:0] C_ST_PAYLOAD = C_ST_ISSUE;
`endif
    localparam int unsigned C_TX_W  = 8 * C_TX_BYTES;
    localparam int unsigned C_RXT_W = $clog2(RX_TIMEOUT + 1);
    localparam int unsigned C_RST_W = $clog2(RESP_TIMEOUT + 1);

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_state_next;
    logic                 r_rw;
    logic                 r_mem_type;
    logic [8:0]           r_addr;
    logic [31:0]          r_data;
    logic [1:0]           r_byte_cnt;
    logic [C_RXT_W-1:0]   r_rx_timer;
    logic [C_RST_W-1:0]   r_resp_timer;
    logic                 r_cpu_seen;
`ifdef UART_MEM_BRIDGE_CSUM_EN
    logic [7:0]           r_csum;
    logic                 w_csum_ok;
`endif
    logic                 w_rx_tmo;
    logic                 w_resp_tmo;
    logic                 w_addr_match;
    logic                 w_cpu_busy;
    logic                 w_ser_done;
    logic                 w_ld;
    logic                 w_ld_resp;
    logic [7:0]           w_stat_byte;
    logic [2:0]           w_ld_len;
    logic [47:0]          w_resp_word;
    logic [C_TX_W-1:0]    w_resp_load;
    logic [C_TX_W-1:0]    w_ld_data;

    assign w_rx_tmo     = (r_rx_timer == C_RXT_W'(RX_TIMEOUT - 1));
    // Timer holds cycles since the request, so a timeout presents ERR exactly RESP_TIMEOUT cycles after it.
    assign w_resp_tmo   = (r_resp_timer == C_RST_W'(RESP_TIMEOUT - 1));
    assign w_addr_match = (mem_tx_data[40:32] == r_addr);
    assign w_cpu_busy   = r_cpu_seen || cpu_enable;
    assign w_resp_word  = {6'b0, mem_tx_data};
`ifdef UART_MEM_BRIDGE_CSUM_EN
    assign w_csum_ok    = (rx_byte == r_csum);
    assign w_resp_load  = {w_resp_word, xor_bytes(w_resp_word)};
`else
    assign w_resp_load  = w_resp_word;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (rx_valid) w_state_next = cpu_enable ? C_ST_TX_STAT : C_ST_RX_ADDR;
            end
            C_ST_RX_ADDR: begin
                if (rx_valid)      w_state_next = r_rw ? C_ST_RX_DATA : C_ST_PAYLOAD;
                else if (w_rx_tmo) w_state_next = C_ST_IDLE;
            end
            C_ST_RX_DATA: begin
                if (rx_valid) begin
                    if (r_byte_cnt == 2'd3) w_state_next = C_ST_PAYLOAD;
                end else if (w_rx_tmo) begin
                    w_state_next = C_ST_IDLE;
                end
            end
`ifdef UART_MEM_BRIDGE_CSUM_EN
            C_ST_RX_CSUM: begin
                if (rx_valid)      w_state_next = w_csum_ok ? C_ST_ISSUE : C_ST_TX_STAT;
                else if (w_rx_tmo) w_state_next = C_ST_IDLE;
            end
`endif
            C_ST_ISSUE: begin
                w_state_next = (w_cpu_busy || r_rw) ? C_ST_TX_STAT : C_ST_WAIT_RESP;
            end
            C_ST_WAIT_RESP: begin
                if (mem_tx_data_ready) w_state_next = w_addr_match ? C_ST_TX_RESP : C_ST_TX_STAT;
                else if (w_resp_tmo)   w_state_next = C_ST_TX_STAT;
            end
            C_ST_TX_RESP, C_ST_TX_STAT: begin
                if (w_ser_done) w_state_next = C_ST_IDLE;
            end
            default: w_state_next = C_ST_IDLE;
        endcase
    end

    // Serializer is loaded on the edge that enters TX_RESP/TX_STAT.
    always_comb begin
        write_mem_req = 1'b0;
        w_ld          = 1'b0;
        w_ld_resp     = 1'b0;
        w_stat_byte   = ERR_BYTE;
        case (r_state)
            C_ST_IDLE: begin
                if (rx_valid && cpu_enable) begin
                    w_ld        = 1'b1;
                    w_stat_byte = BUSY_BYTE;
                end
            end
`ifdef UART_MEM_BRIDGE_CSUM_EN
            C_ST_RX_CSUM: begin
                if (rx_valid && !w_csum_ok) w_ld = 1'b1;
            end
`endif
            C_ST_ISSUE: begin
                if (w_cpu_busy) begin
                    w_ld        = 1'b1;
                    w_stat_byte = BUSY_BYTE;
                end else begin
                    write_mem_req = 1'b1;
                    if (r_rw) begin
                        w_ld        = 1'b1;
                        w_stat_byte = ACK_BYTE;
                    end
                end
            end
            C_ST_WAIT_RESP: begin
                if (mem_tx_data_ready) begin
                    w_ld      = 1'b1;
                    w_ld_resp = w_addr_match;
                end else if (w_resp_tmo) begin
                    w_ld = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_ld_len  = w_ld_resp ? 3'(C_TX_BYTES) : 3'd1;
    assign w_ld_data = w_ld_resp ? w_resp_load : {w_stat_byte, {(C_TX_W-8){1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw         <= 1'b0;
            r_mem_type   <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_byte_cnt   <= '0;
            r_rx_timer   <= '0;
            r_resp_timer <= '0;
            r_cpu_seen   <= 1'b0;
`ifdef UART_MEM_BRIDGE_CSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            if (r_state != C_ST_IDLE) r_cpu_seen <= r_cpu_seen | cpu_enable;
            case (r_state)
                C_ST_IDLE: begin
                    if (rx_valid) begin
                        r_rw       <= rx_byte[C_HDR_RW_BIT];
                        r_mem_type <= rx_byte[C_HDR_TYPE_BIT];
                        r_addr[8]  <= rx_byte[C_HDR_ADDR8_BIT];
                        r_cpu_seen <= 1'b0;
                        r_rx_timer <= '0;
`ifdef UART_MEM_BRIDGE_CSUM_EN
                        r_csum     <= rx_byte;
`endif
                    end
                end
                C_ST_RX_ADDR: begin
                    if (rx_valid) begin
                        r_addr[7:0] <= rx_byte;
                        r_byte_cnt  <= '0;
                        r_rx_timer  <= '0;
`ifdef UART_MEM_BRIDGE_CSUM_EN
                        r_csum      <= r_csum ^ rx_byte;
`endif
                    end else begin
                        r_rx_timer <= r_rx_timer + 1'b1;
                    end
                end
                C_ST_RX_DATA: begin
                    if (rx_valid) begin
                        r_data     <= {r_data[23:0], rx_byte};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_rx_timer <= '0;
`ifdef UART_MEM_BRIDGE_CSUM_EN
                        r_csum     <= r_csum ^ rx_byte;
`endif
                    end else begin
                        r_rx_timer <= r_rx_timer + 1'b1;
                    end
                end
`ifdef UART_MEM_BRIDGE_CSUM_EN
                C_ST_RX_CSUM: begin
                    if (rx_valid) r_rx_timer <= '0;
                    else          r_rx_timer <= r_rx_timer + 1'b1;
                end
`endif
                C_ST_ISSUE:     r_resp_timer <= C_RST_W'(1);
                C_ST_WAIT_RESP: r_resp_timer <= r_resp_timer + 1'b1;
                default: ;
            endcase
        end
    end

    uart_resp_serializer #(
        .MAX_BYTES (C_TX_BYTES)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (w_ld),
        .load_data (w_ld_data),
        .load_len  (w_ld_len),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (w_ser_done)
    );

    assign target_mem_type = r_mem_type;
    assign target_addr     = r_addr;
    assign rw_flag         = r_rw;
    assign uart_rx_data    = r_data;
    assign busy            = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mem_bridge
//  Description : Directed scoreboard bench for uart_mem_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_bridge;

    localparam int unsigned RX_TMO   = 200;
    localparam int unsigned RESP_TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_enable;
    logic        write_mem_req;
    logic        target_mem_type;
    logic [8:0]  target_addr;
    logic        rw_flag;
    logic [31:0] uart_rx_data;
    logic [41:0] mem_tx_data;
    logic        mem_tx_data_ready;
    logic        busy;

    always #5 clk = ~clk;

    uart_mem_bridge #(
        .RX_TIMEOUT   (RX_TMO),
        .RESP_TIMEOUT (RESP_TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_byte           (rx_byte),
        .rx_valid          (rx_valid),
        .tx_byte           (tx_byte),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .cpu_enable        (cpu_enable),
        .write_mem_req     (write_mem_req),
        .target_mem_type   (target_mem_type),
        .target_addr       (target_addr),
        .rw_flag           (rw_flag),
        .uart_rx_data      (uart_rx_data),
        .mem_tx_data       (mem_tx_data),
        .mem_tx_data_ready (mem_tx_data_ready),
        .busy              (busy)
    );

    typedef struct packed {
        logic        rw;
        logic        mtype;
        logic [8:0]  addr;
        logic [31:0] data;
    } req_t;

    req_t        req_q[$];
    logic [7:0]  tx_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_tx = 0;
    int          req_cyc = -1;
    int          valid_cyc = -1;
    bit          prev_valid = 0;
    bit          prev_hold = 0;
    logic [7:0]  prev_byte = 8'h00;
    int          resp_cnt = 0;
    logic [41:0] resp_word = '0;
    bit          resp_arm = 0;
    bit          tx_toggle = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        req_t e;
        if (reset) begin
            prev_hold  = 0;
            prev_valid = 0;
            return;
        end
        if (prev_hold) begin
            check("tx_hold_valid", 64'(tx_valid), 64'd1);
            check("tx_hold_byte", 64'(tx_byte), 64'(prev_byte));
        end
        if (tx_valid && !prev_valid) valid_cyc = cyc;
        prev_valid = tx_valid;
        prev_hold  = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
        if (write_mem_req) begin
            req_cyc = cyc;
            if (req_q.size() == 0) begin
                check("unexpected_req", 64'(write_mem_req), 64'd0);
            end else begin
                e = req_q.pop_front();
                check("req_rw", 64'(rw_flag), 64'(e.rw));
                check("req_type", 64'(target_mem_type), 64'(e.mtype));
                check("req_addr", 64'(target_addr), 64'(e.addr));
                if (e.rw) check("req_data", 64'(uart_rx_data), 64'(e.data));
                if (!e.rw && resp_arm) resp_cnt = 3;
            end
        end
        if (tx_valid && tx_ready) begin
            n_tx++;
            if (tx_q.size() == 0) check("unexpected_tx", 64'(tx_valid), 64'd0);
            else                  check("tx_byte", 64'(tx_byte), 64'(tx_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        mem_tx_data_ready = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_tx_data       = resp_word;
                mem_tx_data_ready = 1'b1;
            end
        end
        if (tx_toggle) tx_ready = ~tx_ready;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f, input int n);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            b  = f[8*(n-1-i) +: 8];
            cs = cs ^ b;
            send_byte(b);
        end
`ifdef UART_MEM_BRIDGE_CSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic expect_resp(input logic [41:0] w);
        logic [47:0] v;
        logic [7:0]  cs;
        logic [7:0]  b;
        v  = {6'b0, w};
        cs = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b  = v[8*(5-i) +: 8];
            cs = cs ^ b;
            tx_q.push_back(b);
        end
`ifdef UART_MEM_BRIDGE_CSUM_EN
        tx_q.push_back(cs);
`endif
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while ((busy || tx_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_tx_left"}, 64'(tx_q.size()), 64'd0);
        check({tag, "_req_left"}, 64'(req_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int k;
        reset             = 1'b1;
        rx_byte           = 8'h00;
        rx_valid          = 1'b0;
        tx_ready          = 1'b1;
        cpu_enable        = 1'b0;
        mem_tx_data       = '0;
        mem_tx_data_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_req", 64'(write_mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(target_addr), 64'd0);
        check("rst_type", 64'(target_mem_type), 64'd0);
        check("rst_rw", 64'(rw_flag), 64'd0);
        check("rst_data", 64'(uart_rx_data), 64'd0);

        // Write to data memory, then ACK.
        req_q.push_back('{1'b1, 1'b0, 9'h005, 32'hDEADBEEF});
        tx_q.push_back(8'hA5);
        send_frame(48'h80_05_DE_AD_BE_EF, 6);
        check("wr_latency", 64'(write_mem_req), 64'd1);
        check("wr_busy", 64'(busy), 64'd1);
        wait_idle(50, "wr");

        // Read with memory response after 3 cycles and a throttled transmitter.
        resp_arm  = 1;
        resp_word = {1'b0, 9'h105, 32'h12345678};
        req_q.push_back('{1'b0, 1'b0, 9'h105, 32'h0});
        expect_resp(resp_word);
        tx_toggle = 1;
        send_frame(48'h01_05, 2);
        wait_idle(100, "rd");
        tx_toggle = 0;
        tx_ready  = 1'b1;

        // Read with no response: ERR exactly RESP_TMO cycles after the request.
        resp_arm = 0;
        req_q.push_back('{1'b0, 1'b0, 9'h009, 32'h0});
        tx_q.push_back(8'hEE);
        send_frame(48'h00_09, 2);
        wait_idle(200, "tmo");
        check("resp_tmo_cycles", 64'(valid_cyc - req_cyc), 64'(RESP_TMO));

        // Response address mismatch -> ERR.
        resp_arm  = 1;
        resp_word = {1'b0, 9'h00B, 32'h0BADF00D};
        req_q.push_back('{1'b0, 1'b1, 9'h00A, 32'h0});
        tx_q.push_back(8'hEE);
        send_frame(48'h40_0A, 2);
        wait_idle(50, "mism");

        // CPU running at header: BUSY, remaining frame bytes dropped.
        cpu_enable = 1'b1;
        tx_ready   = 1'b0;
        tx_q.push_back(8'hE1);
        send_frame(48'h80_05_DE_AD_BE_EF, 6);
        check("busy_stat_valid", 64'(tx_valid), 64'd1);
        check("busy_stat_byte", 64'(tx_byte), 64'hE1);
        tx_ready = 1'b1;
        wait_idle(20, "cpu_hdr");
        cpu_enable = 1'b0;

        // CPU pulse mid-frame: request suppressed, BUSY returned.
        tx_q.push_back(8'hE1);
        send_byte(8'h80);
        send_byte(8'h05);
        cpu_enable = 1'b1;
        tick();
        cpu_enable = 1'b0;
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
`ifdef UART_MEM_BRIDGE_CSUM_EN
        send_byte(8'h80 ^ 8'h05 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        wait_idle(20, "cpu_mid");

        // Inter-byte timeout discards the partial frame silently.
        send_byte(8'h80);
        send_byte(8'h05);
        send_byte(8'hDE);
        repeat (RX_TMO - 10) tick();
        check("rx_tmo_early_busy", 64'(busy), 64'd1);
        repeat (15) tick();
        check("rx_tmo_idle", 64'(busy), 64'd0);
        resp_arm  = 1;
        resp_word = {1'b0, 9'h007, 32'hCAFEF00D};
        req_q.push_back('{1'b0, 1'b0, 9'h007, 32'h0});
        expect_resp(resp_word);
        send_frame(48'h00_07, 2);
        wait_idle(50, "after_rx_tmo");

        // Reset in the middle of a response.
        resp_word = {1'b1, 9'h003, 32'hA1B2C3D4};
        req_q.push_back('{1'b0, 1'b0, 9'h003, 32'h0});
        expect_resp(resp_word);
        base = n_tx;
        send_frame(48'h00_03, 2);
        k = 0;
        while (n_tx < base + 2 && k < 50) begin
            tick();
            k++;
        end
        check("rst_mid_two_bytes", 64'(n_tx - base), 64'd2);
        reset    = 1'b1;
        tx_ready = 1'b0;
        tick();
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_addr", 64'(target_addr), 64'd0);
        reset    = 1'b0;
        tx_ready = 1'b1;
        tx_q.delete();

        req_q.push_back('{1'b1, 1'b1, 9'h011, 32'h01020304});
        tx_q.push_back(8'hA5);
        send_frame(48'hC0_11_01_02_03_04, 6);
        wait_idle(50, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- UART-side debug bridge that drives the data/instruction memory debug-access port (write_mem_req / rw_flag / target_* / response) from host byte frames.
- Parses command frames from the UART receiver byte stream and issues one memory access per frame.
- Serialises the 42-bit memory response, or a status byte, back to the UART transmitter over a valid/ready byte interface.
- Sits between the UART RX/TX byte engines and the memories; access is only legal while the CPU is halted.

Parameters:
- RX_TIMEOUT, 100000: maximum idle clk cycles between bytes of one frame before the frame is discarded.
- RESP_TIMEOUT, 64: maximum clk cycles to wait for mem_tx_data_ready on a read.
- ACK_BYTE, 8'hA5: status byte for a completed write.
- ERR_BYTE, 8'hEE: status byte for a timeout or an address mismatch.
- BUSY_BYTE, 8'hE1: status byte when a command arrives while the CPU is running.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rx_byte  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in this cycle.
- tx_byte  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_byte is valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_byte in any cycle where tx_valid and tx_ready are both high.
- cpu_enable  in  1  CPU run enable, the same signal the memories see as enable.
- write_mem_req  out  1  one-cycle access request to the memories.
- target_mem_type  out  1  0 = data memory, 1 = instruction memory.
- target_addr  out  9  word address.
- rw_flag  out  1  1 = write, 0 = read.
- uart_rx_data  out  32  write data to the memory.
- mem_tx_data  in  42  {flag, addr[8:0], data[31:0]} from the selected memory.
- mem_tx_data_ready  in  1  one-cycle strobe; mem_tx_data is valid.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs are 0; state goes to IDLE; all counters are cleared. Reset takes effect from any state and aborts any frame or transmission in progress (tx_valid drops the next cycle).
- Command frame, bytes received MSB-first:
  - H = header: bit7 = rw_flag, bit6 = mem_type, bit0 = addr[8], bits 5:1 ignored.
  - A = addr[7:0].
  - Write frames add four data bytes D3..D0 (big-endian).
- States: IDLE, RX_ADDR, RX_DATA, ISSUE, WAIT_RESP, TX_RESP, TX_STAT.
- IDLE:
  - rx_valid captures H into the command registers.
  - If cpu_enable=1, load BUSY_BYTE and go to TX_STAT; otherwise go to RX_ADDR.
- RX_ADDR: rx_valid captures A. A write goes to RX_DATA with byte count 0; a read goes to ISSUE.
- RX_DATA: each rx_valid shifts into uart_rx_data; after the 4th byte, go to ISSUE.
- Inter-byte timeout: in RX_ADDR and RX_DATA, a counter resets on every rx_valid. At RX_TIMEOUT the state returns to IDLE silently with no response.
- ISSUE:
  - write_mem_req=1 for exactly one cycle.
  - target_mem_type, target_addr, rw_flag and uart_rx_data are stable from ISSUE until IDLE is re-entered.
  - If cpu_enable rose since H, send BUSY_BYTE and do not issue the request.
  - After the request: a write loads ACK_BYTE and goes to TX_STAT; a read goes to WAIT_RESP.
- WAIT_RESP:
  - mem_tx_data_ready captures mem_tx_data.
  - If mem_tx_data[40:32] equals target_addr, go to TX_RESP; otherwise load ERR_BYTE and go to TX_STAT.
  - A wait of RESP_TIMEOUT cycles loads ERR_BYTE and goes to TX_STAT. A ready strobe arriving in the same cycle as the timeout wins.
- TX_RESP:
  - Sends 6 bytes of {6'b0, resp[41:0]}, MSB byte first.
  - tx_byte changes only after a handshake. The next byte is presented the cycle after acceptance.
  - After the 6th accepted byte, go to IDLE.
- TX_STAT: sends one byte, then goes to IDLE.
- Bytes arriving in ISSUE, WAIT_RESP, TX_RESP or TX_STAT are dropped.
- Latency: write_mem_req is asserted 1 cycle after the cycle in which the final frame byte is strobed.

Optional Feature:
- Macro: UART_MEM_BRIDGE_CSUM_EN.
- When defined:
  - Each command frame carries one extra trailing byte, equal to the XOR of all preceding frame bytes; it is received in a new RX_CSUM state.
  - On mismatch, no request is issued and ERR_BYTE is sent.
  - TX_RESP appends a 7th byte, equal to the XOR of the 6 response bytes.
- When undefined: no checksum byte in either direction, and no RX_CSUM state.

Decomposition:
- Shared package uart_dbg_pkg holds:
  - the state encoding;
  - the header bit positions;
  - the ACK/ERR/BUSY byte constants;
  - the response width constant 42.
- One natural sub-module: uart_resp_serializer. It performs the parallel-load of 48/56 bits and shifts out bytes under the valid/ready handshake; TX_STAT reuses it with a 1-byte length.

Test Plan:
- CPU halted; send 80 05 DE AD BE EF -> one-cycle write_mem_req, rw_flag=1, type=0, addr=0x005, data=0xDEADBEEF; then tx byte A5.
- Read 01 05; memory returns {0, 9'h105, 32'h12345678} after 3 cycles -> tx bytes 01 05 12 34 56 78; with tx_ready toggled every other cycle, each byte is held until accepted.
- Read with no mem_tx_data_ready -> tx EE exactly RESP_TIMEOUT cycles after the request.
- cpu_enable=1; send 80 -> tx E1 and no write_mem_req ever; the following bytes of the frame are dropped.
- Send 80 05 DE, then idle for RX_TIMEOUT cycles -> no request and no tx; a fresh 00 07 then reads address 0x007.
- Assert reset mid-TX_RESP after 2 bytes -> tx_valid=0 and busy=0 next cycle; the next frame is processed normally.
